// File: rtl/pp_channel_monitor.sv
// -----------------------------------------------------------------------------
// pp_channel_monitor
//   Passive rdy/ack protocol monitor for NCH independent pipeline channels.
//   It sits beside a link and never drives it. For each channel it:
//     - checks the hold rule (no ack without rdy, no drop, stable data),
//     - counts completed transfers,
//     - tracks the longest stall.
//   Violations are reported through a one-cycle strobe (err_vld/err_ch/err_code)
//   and through per-channel sticky flags. Transfer and stall statistics of one
//   channel can be read back through a channel-selectable port.
//
//   Optional feature macro: PP_MONITOR_TIMEOUT_EN
//     defined   : stall TIMEOUT check (error code 3) and per-channel to_done
//     undefined : no timeout logic, code 3 never produced
//
// Parameters
//   NCH      number of monitored channels (1..16)
//   BW       data width per channel
//   CNT_W    width of the transfer and stall counters
//   TIMEOUT  consecutive stall cycles that raise TIMEOUT (1..2^CNT_W-1)
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   rdy[NCH]      per-channel valid from producer
//   ack[NCH]      per-channel accept from consumer
//   dat[NCH*BW]   channel i on dat[i*BW +: BW]
//   clr           synchronous clear of counters, flags and pending state
//   sel           channel selected for readback (out of range reads zero)
//   rd_xfer       transfer count of channel sel
//   rd_stall_max  longest stall of channel sel
//   err_sticky    per-channel sticky error flags
//   err_vld       one-cycle error strobe
//   err_ch        lowest-index channel that erred on the reported edge
//   err_code      0 ACK_NO_RDY, 1 DROP, 2 DATA, 3 TIMEOUT
// -----------------------------------------------------------------------------
module pp_channel_monitor #(
  parameter int NCH     = 4,
  parameter int BW      = 8,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1023,
  localparam int SEL_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCH-1:0]      rdy,
  input  logic [NCH-1:0]      ack,
  input  logic [NCH*BW-1:0]   dat,
  input  logic                clr,
  input  logic [SEL_W-1:0]    sel,
  output logic [CNT_W-1:0]    rd_xfer,
  output logic [CNT_W-1:0]    rd_stall_max,
  output logic [NCH-1:0]      err_sticky,
  output logic                err_vld,
  output logic [SEL_W-1:0]    err_ch,
  output logic [1:0]          err_code
);

  localparam logic [1:0] CODE_ACK_NO_RDY = 2'd0;
  localparam logic [1:0] CODE_DROP       = 2'd1;
  localparam logic [1:0] CODE_DATA       = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT    = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_TO   = CNT_W'(TIMEOUT);

  // Per-channel registered state
  logic [NCH-1:0]   pend_r;
  logic [BW-1:0]    prev_dat_r  [NCH];
  logic [CNT_W-1:0] stall_r     [NCH];
  logic [CNT_W-1:0] stall_max_r [NCH];
  logic [CNT_W-1:0] xfer_r      [NCH];
`ifdef PP_MONITOR_TIMEOUT_EN
  logic [NCH-1:0]   to_done_r;
`endif

  // Registered report outputs
  logic [NCH-1:0]   err_sticky_r;
  logic             err_vld_r;
  logic [SEL_W-1:0] err_ch_r;
  logic [1:0]       err_code_r;

  // Per-channel combinational results
  logic [CNT_W-1:0] stall_inc_s [NCH];
  logic [NCH-1:0]   stall_cyc_s;
  logic [NCH-1:0]   hit_s;
  logic [1:0]       code_s      [NCH];
  logic             any_s;
  logic [SEL_W-1:0] first_ch_s;
  logic [1:0]       first_code_s;

  // Per-channel error classification in priority order, then lowest-index pick
  always_comb begin
    any_s        = 1'b0;
    first_ch_s   = '0;
    first_code_s = 2'd0;
    for (int i = 0; i < NCH; i++) begin
      stall_cyc_s[i] = rdy[i] & ~ack[i];
      // Saturating increment; the stall counter never wraps back to zero
      if (stall_r[i] == CNT_MAX) begin
        stall_inc_s[i] = stall_r[i];
      end else begin
        stall_inc_s[i] = stall_r[i] + CNT_ONE;
      end
      hit_s[i]  = 1'b0;
      code_s[i] = CODE_ACK_NO_RDY;
      if (ack[i] && !rdy[i]) begin
        hit_s[i]  = 1'b1;
        code_s[i] = CODE_ACK_NO_RDY;
      end else if (pend_r[i] && !rdy[i]) begin
        hit_s[i]  = 1'b1;
        code_s[i] = CODE_DROP;
      end else if (pend_r[i] && rdy[i] && (dat[i*BW +: BW] != prev_dat_r[i])) begin
        hit_s[i]  = 1'b1;
        code_s[i] = CODE_DATA;
      end else begin
`ifdef PP_MONITOR_TIMEOUT_EN
        if (stall_cyc_s[i] && (stall_inc_s[i] == CNT_TO) && !to_done_r[i]) begin
          hit_s[i]  = 1'b1;
          code_s[i] = CODE_TIMEOUT;
        end else begin
          hit_s[i]  = 1'b0;
        end
`else
        hit_s[i]  = 1'b0;
`endif
      end
    end
    // Walk downwards so the lowest-index erring channel wins
    for (int i = NCH - 1; i >= 0; i--) begin
      if (hit_s[i]) begin
        any_s        = 1'b1;
        first_ch_s   = SEL_W'(i);
        first_code_s = code_s[i];
      end else begin
        any_s        = any_s;
      end
    end
  end

  // Channel state update: pending, counters, stall tracking; clr overrides all
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r <= '0;
      for (int i = 0; i < NCH; i++) begin
        stall_r[i]     <= '0;
        stall_max_r[i] <= '0;
        xfer_r[i]      <= '0;
      end
    end else if (clr) begin
      pend_r <= '0;
      for (int i = 0; i < NCH; i++) begin
        stall_r[i]     <= '0;
        stall_max_r[i] <= '0;
        xfer_r[i]      <= '0;
      end
    end else begin
      pend_r <= rdy & ~ack;
      for (int i = 0; i < NCH; i++) begin
        if (rdy[i] && ack[i] && (xfer_r[i] != CNT_MAX)) begin
          xfer_r[i] <= xfer_r[i] + CNT_ONE;
        end else begin
          xfer_r[i] <= xfer_r[i];
        end
        if (stall_cyc_s[i]) begin
          stall_r[i] <= stall_inc_s[i];
          if (stall_inc_s[i] > stall_max_r[i]) begin
            stall_max_r[i] <= stall_inc_s[i];
          end else begin
            stall_max_r[i] <= stall_max_r[i];
          end
        end else begin
          stall_r[i]     <= '0;
          stall_max_r[i] <= stall_max_r[i];
        end
      end
    end
  end

`ifdef PP_MONITOR_TIMEOUT_EN
  // One-shot timeout latch per stall episode; re-armed when the stall ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_done_r <= '0;
    end else if (clr) begin
      to_done_r <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!stall_cyc_s[i]) begin
          to_done_r[i] <= 1'b0;
        end else if (stall_inc_s[i] == CNT_TO) begin
          to_done_r[i] <= 1'b1;
        end else begin
          to_done_r[i] <= to_done_r[i];
        end
      end
    end
  end
`endif

  // Last presented data, reference for the stable-data check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        prev_dat_r[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (rdy[i]) begin
          prev_dat_r[i] <= dat[i*BW +: BW];
        end else begin
          prev_dat_r[i] <= prev_dat_r[i];
        end
      end
    end
  end

  // Error report registers: one-cycle strobe plus sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_r <= '0;
      err_vld_r    <= 1'b0;
      err_ch_r     <= '0;
      err_code_r   <= 2'd0;
    end else if (clr) begin
      err_sticky_r <= '0;
      err_vld_r    <= 1'b0;
      err_ch_r     <= '0;
      err_code_r   <= 2'd0;
    end else begin
      err_sticky_r <= err_sticky_r | hit_s;
      err_vld_r    <= any_s;
      err_ch_r     <= first_ch_s;
      err_code_r   <= first_code_s;
    end
  end

  // Statistics readback mux; out-of-range channel numbers read zero
  always_comb begin
    rd_xfer      = '0;
    rd_stall_max = '0;
    if (32'(sel) < NCH) begin
      rd_xfer      = xfer_r[sel];
      rd_stall_max = stall_max_r[sel];
    end else begin
      rd_xfer      = '0;
      rd_stall_max = '0;
    end
  end

  assign err_sticky = err_sticky_r;
  assign err_vld    = err_vld_r;
  assign err_ch     = err_ch_r;
  assign err_code   = err_code_r;

endmodule

// File: tb/tb_pp_channel_monitor.sv
// -----------------------------------------------------------------------------
// tb_pp_channel_monitor
//   Directed self-checking bench for pp_channel_monitor with NCH=4, BW=8,
//   CNT_W=16, TIMEOUT=8. Inputs change 1 ns after a rising edge; outputs are
//   sampled at the same point, i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_pp_channel_monitor;

  localparam int NCH     = 4;
  localparam int BW      = 8;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    rdy;
  logic [NCH-1:0]    ack;
  logic [NCH*BW-1:0] dat;
  logic              clr;
  logic [1:0]        sel;
  logic [CNT_W-1:0]  rd_xfer;
  logic [CNT_W-1:0]  rd_stall_max;
  logic [NCH-1:0]    err_sticky;
  logic              err_vld;
  logic [1:0]        err_ch;
  logic [1:0]        err_code;

  int checks = 0;
  int errors = 0;

  pp_channel_monitor #(
    .NCH(NCH), .BW(BW), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .ack(ack), .dat(dat), .clr(clr),
    .sel(sel), .rd_xfer(rd_xfer), .rd_stall_max(rd_stall_max),
    .err_sticky(err_sticky), .err_vld(err_vld), .err_ch(err_ch),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rdy = '0;
    ack = '0;
    dat = '0;
    clr = 1'b0;
  endtask

  task automatic do_clr();
    idle_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    sel = 2'd0;
    #12;
    checks++; if (rd_xfer !== 16'd0) begin errors++; $display("FAIL reset_xfer: got %0d expected 0", rd_xfer); end
    checks++; if (rd_stall_max !== 16'd0) begin errors++; $display("FAIL reset_stall_max: got %0d expected 0", rd_stall_max); end
    checks++; if (err_sticky !== 4'b0000) begin errors++; $display("FAIL reset_sticky: got %b expected 0000", err_sticky); end
    checks++; if (err_vld !== 1'b0) begin errors++; $display("FAIL reset_err_vld: got %b expected 0", err_vld); end
    checks++; if (err_ch !== 2'd0 || err_code !== 2'd0) begin errors++; $display("FAIL reset_err_ch_code: got ch=%0d code=%0d expected 0/0", err_ch, err_code); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_clean_traffic();
    do_clr();
    for (int k = 0; k < 10; k++) begin
      rdy[0] = 1'b1;
      ack[0] = 1'b1;
      dat[7:0] = 8'(k);
      tick();
      checks++; if (err_vld !== 1'b0) begin errors++; $display("FAIL clean_err_vld cycle %0d: got %b expected 0", k, err_vld); end
    end
    sel = 2'd0;
    checks++; if (rd_xfer !== 16'd10) begin errors++; $display("FAIL clean_xfer: got %0d expected 10", rd_xfer); end
    checks++; if (rd_stall_max !== 16'd0) begin errors++; $display("FAIL clean_stall_max: got %0d expected 0", rd_stall_max); end
    idle_inputs();
    tick();
  endtask

  task automatic test_data_error();
    do_clr();
    rdy[1] = 1'b1;
    ack[1] = 1'b0;
    dat[15:8] = 8'h55;
    tick();
    checks++; if (err_vld !== 1'b0) begin errors++; $display("FAIL data_first_edge: got err_vld=%b expected 0", err_vld); end
    dat[15:8] = 8'h56;
    tick();
    checks++; if (err_vld !== 1'b1) begin errors++; $display("FAIL data_err_vld: got %b expected 1", err_vld); end
    checks++; if (err_ch !== 2'd1 || err_code !== 2'd2) begin errors++; $display("FAIL data_ch_code: got ch=%0d code=%0d expected 1/2", err_ch, err_code); end
    checks++; if (err_sticky !== 4'b0010) begin errors++; $display("FAIL data_sticky: got %b expected 0010", err_sticky); end
    // Complete the transfer with the held value: no error, strobe drops
    ack[1] = 1'b1;
    tick();
    checks++; if (err_vld !== 1'b0) begin errors++; $display("FAIL data_strobe_one_cycle: got %b expected 0", err_vld); end
    checks++; if (err_sticky !== 4'b0010) begin errors++; $display("FAIL data_sticky_held: got %b expected 0010", err_sticky); end
    idle_inputs();
    tick();
  endtask

  task automatic test_priority();
    do_clr();
    rdy[2] = 1'b1;
    ack[2] = 1'b0;
    tick();
    rdy[2] = 1'b0;
    ack[3] = 1'b1;
    rdy[3] = 1'b0;
    tick();
    checks++; if (err_vld !== 1'b1 || err_ch !== 2'd2 || err_code !== 2'd1) begin errors++; $display("FAIL prio_report: got vld=%b ch=%0d code=%0d expected 1/2/1", err_vld, err_ch, err_code); end
    checks++; if (err_sticky !== 4'b1100) begin errors++; $display("FAIL prio_sticky: got %b expected 1100", err_sticky); end
    idle_inputs();
    tick();
  endtask

  task automatic run_stall(input int len, output int n_err, output int fire_edge, output logic [1:0] code);
    n_err = 0;
    fire_edge = 0;
    code = 2'd0;
    for (int k = 1; k <= len; k++) begin
      rdy[0] = 1'b1;
      ack[0] = 1'b0;
      dat[7:0] = 8'hA0;
      tick();
      if (err_vld === 1'b1) begin
        n_err++;
        fire_edge = k;
        code = err_code;
      end
    end
    ack[0] = 1'b1;
    tick();
    if (err_vld === 1'b1) n_err++;
    idle_inputs();
    tick();
    if (err_vld === 1'b1) n_err++;
  endtask

  task automatic test_stall_timeout();
    int n_err;
    int fire_edge;
    logic [1:0] code;
    do_clr();
    sel = 2'd0;
    run_stall(10, n_err, fire_edge, code);
`ifdef PP_MONITOR_TIMEOUT_EN
    checks++; if (n_err !== 1 || fire_edge !== 8 || code !== 2'd3) begin errors++; $display("FAIL timeout_first: got count=%0d edge=%0d code=%0d expected 1/8/3", n_err, fire_edge, code); end
`else
    checks++; if (n_err !== 0) begin errors++; $display("FAIL timeout_disabled_first: got %0d strobes expected 0", n_err); end
`endif
    checks++; if (rd_stall_max !== 16'd10) begin errors++; $display("FAIL stall_max_first: got %0d expected 10", rd_stall_max); end
    checks++; if (rd_xfer !== 16'd1) begin errors++; $display("FAIL stall_xfer_first: got %0d expected 1", rd_xfer); end
    run_stall(9, n_err, fire_edge, code);
`ifdef PP_MONITOR_TIMEOUT_EN
    checks++; if (n_err !== 1 || fire_edge !== 8 || code !== 2'd3) begin errors++; $display("FAIL timeout_second: got count=%0d edge=%0d code=%0d expected 1/8/3", n_err, fire_edge, code); end
    checks++; if (err_sticky !== 4'b0001) begin errors++; $display("FAIL timeout_sticky: got %b expected 0001", err_sticky); end
`else
    checks++; if (n_err !== 0) begin errors++; $display("FAIL timeout_disabled_second: got %0d strobes expected 0", n_err); end
    checks++; if (err_sticky !== 4'b0000) begin errors++; $display("FAIL timeout_disabled_sticky: got %b expected 0000", err_sticky); end
`endif
    checks++; if (rd_stall_max !== 16'd10) begin errors++; $display("FAIL stall_max_second: got %0d expected 10", rd_stall_max); end
    checks++; if (rd_xfer !== 16'd2) begin errors++; $display("FAIL stall_xfer_second: got %0d expected 2", rd_xfer); end
  endtask

  task automatic test_clr_precedence();
    do_clr();
    rdy[0] = 1'b1; ack[0] = 1'b1;
    rdy[1] = 1'b1; ack[1] = 1'b0; dat[15:8] = 8'h11;
    tick();
    dat[15:8] = 8'h12;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (err_vld !== 1'b0) begin errors++; $display("FAIL clr_err_vld: got %b expected 0", err_vld); end
    checks++; if (err_sticky !== 4'b0000) begin errors++; $display("FAIL clr_sticky: got %b expected 0000", err_sticky); end
    sel = 2'd0;
    #1;
    checks++; if (rd_xfer !== 16'd0) begin errors++; $display("FAIL clr_xfer_ch0: got %0d expected 0", rd_xfer); end
    sel = 2'd1;
    #1;
    checks++; if (rd_stall_max !== 16'd0 || rd_xfer !== 16'd0) begin errors++; $display("FAIL clr_ch1_counters: got stall_max=%0d xfer=%0d expected 0/0", rd_stall_max, rd_xfer); end
    // Pending was cleared, so dropping rdy now is not a DROP
    idle_inputs();
    tick();
    checks++; if (err_vld !== 1'b0) begin errors++; $display("FAIL clr_pend_cleared: got err_vld=%b expected 0", err_vld); end
  endtask

  task automatic test_async_reset();
    int n_err;
    do_clr();
    sel = 2'd0;
    rdy[0] = 1'b1; ack[0] = 1'b0; dat[7:0] = 8'h33;
    tick();
    tick();
    ack[3] = 1'b1;
    tick();
    checks++; if (err_vld !== 1'b1 || err_ch !== 2'd3 || err_code !== 2'd0 || rd_stall_max !== 16'd3) begin errors++; $display("FAIL areset_pre: got vld=%b ch=%0d code=%0d stall_max=%0d expected 1/3/0/3", err_vld, err_ch, err_code, rd_stall_max); end
    ack[3] = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (err_vld !== 1'b0 || err_sticky !== 4'b0000 || err_ch !== 2'd0 || err_code !== 2'd0) begin errors++; $display("FAIL areset_err_outputs: got vld=%b sticky=%b ch=%0d code=%0d expected all 0", err_vld, err_sticky, err_ch, err_code); end
    checks++; if (rd_stall_max !== 16'd0 || rd_xfer !== 16'd0) begin errors++; $display("FAIL areset_counters: got stall_max=%0d xfer=%0d expected 0/0", rd_stall_max, rd_xfer); end
    #1;
    rst_n = 1'b1;
    n_err = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (err_vld === 1'b1) n_err++;
    end
    checks++; if (n_err !== 0) begin errors++; $display("FAIL areset_no_error: got %0d strobes expected 0", n_err); end
    checks++; if (rd_stall_max !== 16'd6) begin errors++; $display("FAIL areset_stall_restart: got %0d expected 6", rd_stall_max); end
    ack[0] = 1'b1;
    tick();
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_clean_traffic();
    test_data_error();
    test_priority();
    test_stall_timeout();
    test_clr_precedence();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
